t07_wb_manager: RTL and testbench

- Wishbone B4 classic single-master bridge between the t07 MMIO decoder and instruction/data memory.
- Takes the MMIO level-style read/write requests and runs one CYC/STB/ACK transaction per request.
- Returns read data and the busy and busy-edge status that MMIO uses to stall the CPU and suppress re-issue.
- Includes an ACK timeout so a dead slave cannot hang the core.

---
 rtl/t07_wb_pkg.sv | 14 +
 rtl/t07_wb_manager.sv | 162 ++++++++++++++++
 tb/tb_t07_wb_manager.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/t07_wb_pkg.sv
// Shared types and constants for the t07 Wishbone manager.
package t07_wb_pkg;

   // Transaction sequencer states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } wb_state_t;

   localparam logic [3:0]  WB_SEL_FULL = 4'hF;
   localparam logic [31:0] WB_ERR_DATA = 32'hDEADBEEF;

endpackage : t07_wb_pkg

// File: rtl/t07_wb_manager.sv
// Wishbone B4 classic single-master bridge for the t07 MMIO decoder.
// One CYC/STB/ACK transaction per level request, with an ACK timeout
// so a dead slave cannot hang the core. DONE lasts one cycle so MMIO
// can drop its request before the next accept.
module t07_wb_manager
   import t07_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = WB_ERR_DATA
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        read_i,
   input  logic        write_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] data_o,
   output logic        busy_o,
   output logic        busy_edge_o,
   output logic        err_o,
   output logic [31:0] adr_o,
   output logic [31:0] dat_o,
   output logic [3:0]  sel_o,
   output logic        we_o,
   output logic        cyc_o,
   output logic        stb_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   wb_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic [31:0]   data_q, data_d;
   logic          we_q, we_d;
   logic          cyc_q, cyc_d;
   logic          edge_q, edge_d;
   logic          err_q, err_d;
   logic          req_s;

   assign req_s = read_i | write_i;

   // Next-state and bus-register update for the IDLE/BUSY/DONE sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      data_d  = data_q;
      we_d    = we_q;
      cyc_d   = cyc_q;
      edge_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_s) begin
               adr_d   = addr_i;
               if (write_i) begin
                  dat_d = wdata_i;
               end else begin
                  dat_d = dat_q;
               end
               we_d    = write_i;
               cyc_d   = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CNT_ONE;
            if (ack_i) begin
               // An ack on the timeout cycle is still a normal completion.
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               if (!we_q) begin
                  data_d = dat_i;
               end else begin
                  data_d = data_q;
               end
               edge_d  = 1'b1;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               if (!we_q) begin
                  data_d = ERR_DATA;
               end else begin
                  data_d = data_q;
               end
               edge_d  = 1'b1;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            // Requests still high here are the ones just served; ignore them.
            state_d = IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously so a reset drops CYC/STB at once.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= 32'h0000_0000;
         dat_q   <= 32'h0000_0000;
         data_q  <= 32'h0000_0000;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         edge_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         data_q  <= data_d;
         we_q    <= we_d;
         cyc_q   <= cyc_d;
         edge_q  <= edge_d;
         err_q   <= err_d;
      end
   end

   // Busy stalls the CPU in the issue cycle and throughout BUSY, but not in DONE.
   always_comb begin
      busy_o = 1'b0;
      case (state_q)
         IDLE:    busy_o = req_s;
         BUSY:    busy_o = 1'b1;
         DONE:    busy_o = 1'b0;
         default: busy_o = 1'b0;
      endcase
   end

   assign data_o      = data_q;
   assign busy_edge_o = edge_q;
   assign err_o       = err_q;
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
   assign sel_o       = WB_SEL_FULL;
   assign we_o        = we_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;

endmodule : t07_wb_manager

// File: tb/tb_t07_wb_manager.sv
// Directed testbench for t07_wb_manager (built with a 4-cycle ACK timeout).
module tb_t07_wb_manager;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        read_i = 1'b0;
   logic        write_i = 1'b0;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] wdata_i = 32'h0;
   logic [31:0] data_o;
   logic        busy_o;
   logic        busy_edge_o;
   logic        err_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [3:0]  sel_o;
   logic        we_o;
   logic        cyc_o;
   logic        stb_o;
   logic [31:0] dat_i = 32'h0;
   logic        ack_i = 1'b0;

   int checks = 0;
   int errors = 0;

   t07_wb_manager #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .nrst(nrst), .read_i(read_i), .write_i(write_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .data_o(data_o), .busy_o(busy_o),
      .busy_edge_o(busy_edge_o), .err_o(err_o), .adr_o(adr_o), .dat_o(dat_o),
      .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
      .dat_i(dat_i), .ack_i(ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with a request and a toggling ack.
      nrst = 1'b0; read_i = 1'b1; addr_i = 32'h33000010;
      for (int i = 0; i < 4; i++) begin
         ack_i = ~ack_i;
         step();
      end
      chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
      chk("rst_stb", {31'd0, stb_o}, 32'd0);
      chk("rst_data", data_o, 32'h0);
      chk("rst_adr", adr_o, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_we", {31'd0, we_o}, 32'd0);
      chk("rst_edge", {31'd0, busy_edge_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_sel", {28'd0, sel_o}, 32'hF);
      read_i = 1'b0; ack_i = 1'b0;
      nrst = 1'b1;
      step();
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      chk("idle_cyc", {31'd0, cyc_o}, 32'd0);

      // Read with two wait states.
      read_i = 1'b1; addr_i = 32'h33000010;
      #1;
      chk("rd_issue_busy", {31'd0, busy_o}, 32'd1);
      step();
      chk("rd_cyc", {31'd0, cyc_o}, 32'd1);
      chk("rd_stb", {31'd0, stb_o}, 32'd1);
      chk("rd_adr", adr_o, 32'h33000010);
      chk("rd_we", {31'd0, we_o}, 32'd0);
      step();
      chk("rd_hold_cyc", {31'd0, cyc_o}, 32'd1);
      step();
      ack_i = 1'b1; dat_i = 32'hCAFEF00D;
      step();
      chk("rd_data", data_o, 32'hCAFEF00D);
      chk("rd_edge", {31'd0, busy_edge_o}, 32'd1);
      chk("rd_err", {31'd0, err_o}, 32'd0);
      chk("rd_done_busy", {31'd0, busy_o}, 32'd0);
      chk("rd_done_cyc", {31'd0, cyc_o}, 32'd0);
      ack_i = 1'b0; read_i = 1'b0;
      step();
      chk("rd_edge_off", {31'd0, busy_edge_o}, 32'd0);

      // Write with zero wait states.
      write_i = 1'b1; addr_i = 32'h33000420; wdata_i = 32'h12345678;
      step();
      chk("wr_adr", adr_o, 32'h33000420);
      chk("wr_dat", dat_o, 32'h12345678);
      chk("wr_we", {31'd0, we_o}, 32'd1);
      chk("wr_sel", {28'd0, sel_o}, 32'hF);
      ack_i = 1'b1; dat_i = 32'h0BADF00D;
      step();
      chk("wr_edge", {31'd0, busy_edge_o}, 32'd1);
      chk("wr_data_kept", data_o, 32'hCAFEF00D);
      chk("wr_we_drop", {31'd0, we_o}, 32'd0);
      write_i = 1'b0; ack_i = 1'b0;
      step();
      chk("wr_edge_once", {31'd0, busy_edge_o}, 32'd0);

      // Timeout: no ack for four BUSY cycles.
      read_i = 1'b1; addr_i = 32'h33000100;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("to_cyc_high", {31'd0, cyc_o}, 32'd1);
      end
      step();
      chk("to_cyc_low", {31'd0, cyc_o}, 32'd0);
      chk("to_data", data_o, 32'hDEADBEEF);
      chk("to_err", {31'd0, err_o}, 32'd1);
      chk("to_edge", {31'd0, busy_edge_o}, 32'd1);
      read_i = 1'b0;
      step();
      chk("to_err_off", {31'd0, err_o}, 32'd0);
      chk("to_edge_off", {31'd0, busy_edge_o}, 32'd0);

      // Held request across completion.
      read_i = 1'b1; addr_i = 32'h33000200;
      step();
      ack_i = 1'b1; dat_i = 32'h11112222;
      step();
      chk("hold_edge", {31'd0, busy_edge_o}, 32'd1);
      chk("hold_done_busy", {31'd0, busy_o}, 32'd0);
      chk("hold_data1", data_o, 32'h11112222);
      ack_i = 1'b0;
      step();
      chk("hold_no_accept", {31'd0, cyc_o}, 32'd0);
      chk("hold_idle_busy", {31'd0, busy_o}, 32'd1);
      step();
      chk("hold_accept", {31'd0, cyc_o}, 32'd1);
      ack_i = 1'b1; dat_i = 32'h33334444;
      step();
      chk("hold_data2", data_o, 32'h33334444);
      read_i = 1'b0; ack_i = 1'b0;
      step();
      // Stray ack in IDLE.
      ack_i = 1'b1; dat_i = 32'h55556666;
      step();
      chk("stray_cyc", {31'd0, cyc_o}, 32'd0);
      chk("stray_edge", {31'd0, busy_edge_o}, 32'd0);
      chk("stray_data", data_o, 32'h33334444);
      ack_i = 1'b0;
      step();

      // Reset in the middle of a transaction.
      read_i = 1'b1; addr_i = 32'h33000300;
      step();
      chk("mid_cyc", {31'd0, cyc_o}, 32'd1);
      #2 nrst = 1'b0;
      #1;
      chk("mid_async_cyc", {31'd0, cyc_o}, 32'd0);
      chk("mid_async_stb", {31'd0, stb_o}, 32'd0);
      read_i = 1'b0;
      step();
      chk("mid_edge", {31'd0, busy_edge_o}, 32'd0);
      chk("mid_data", data_o, 32'h0);
      nrst = 1'b1;
      step();
      chk("mid_idle_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_idle_edge", {31'd0, busy_edge_o}, 32'd0);
      chk("mid_idle_cyc", {31'd0, cyc_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_t07_wb_manager
